// File: rtl/unidade_acesso_memoria_pkg.sv
// Shared constants for the load/store unit: default widths and FSM state encoding.
package unidade_acesso_memoria_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    READ  = 2'b10,
    RESP  = 2'b11
  } state_t;

endpackage

// File: rtl/unidade_acesso_memoria_fwd_reg.sv
// acesso_fwd_reg: one-entry store-forwarding register plus address compare.
// Holds {valid, addr, data} of the last completed store; reset clears valid.
module acesso_fwd_reg #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_done,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [ADDR_W-1:0] lk_addr,
  output logic              hit,
  output logic [DATA_W-1:0] fwd_data
);

  logic              ent_valid;
  logic [ADDR_W-1:0] ent_addr;
  logic [DATA_W-1:0] ent_data;

  // Capture the store as it commits to memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_valid <= 1'b0;
      ent_addr  <= '0;
      ent_data  <= '0;
    end else if (st_done) begin
      ent_valid <= 1'b1;
      ent_addr  <= st_addr;
      ent_data  <= st_data;
    end
  end

  assign hit      = ent_valid && (ent_addr == lk_addr);
  assign fwd_data = ent_data;

endmodule

// File: rtl/unidade_acesso_memoria.sv
// unidade_acesso_memoria: load/store unit in front of memoria_dados.
// One request in flight: IDLE -> WRITE|READ -> RESP -> IDLE.
// All memory-side outputs are registered, so req_* never reaches mem_* combinationally.
// Optional build macro UNIDADE_ACESSO_STORE_FWD_EN: loads hitting the last completed
// store skip the memory access and respond one cycle after acceptance.
import unidade_acesso_memoria_pkg::*;

module unidade_acesso_memoria #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  st_count
);

  state_t            state, state_n;
  logic              accept;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic              fwd_load;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign fwd_load  = accept & ~req_we & fwd_hit;

`ifdef UNIDADE_ACESSO_STORE_FWD_EN
  acesso_fwd_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fwd (
    .clk      (clk),
    .rst      (rst),
    .st_done  (state == WRITE),
    .st_addr  (mem_addr),
    .st_data  (mem_wdata),
    .lk_addr  (req_addr),
    .hit      (fwd_hit),
    .fwd_data (fwd_data)
  );
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state: stores go to WRITE, forwarded loads straight to RESP, other loads to READ.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_we)       state_n = WRITE;
          else if (fwd_hit) state_n = RESP;
          else              state_n = READ;
        end
      end
      WRITE:   state_n = RESP;
      READ:    state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Registered memory interface, response and store counter.
  // mem_we/resp_valid are decoded from the next state so they line up with WRITE/RESP
  // and drop asynchronously with reset (an in-flight write is aborted).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      st_count   <= '0;
    end else begin
      mem_we     <= (state_n == WRITE);
      resp_valid <= (state_n == RESP);
      // Forwarded loads leave the memory address untouched.
      if (accept && !fwd_load) begin
        mem_addr  <= req_addr;
        mem_wdata <= req_wdata;
      end
      if (fwd_load)        resp_rdata <= fwd_data;
      if (state == WRITE) begin
        resp_rdata <= mem_wdata;
        st_count   <= st_count + CNT_W'(1);
      end
      if (state == READ)   resp_rdata <= mem_rdata;
    end
  end

endmodule
